add3_seq_ctrl: RTL



---
 rtl/add3_seq_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/add3_seq_ctrl.sv
// Three-operand adder controller: A + B + C + c_in computed over two cycles
// on a single shared Kogge-Stone adder, with valid/ready handshakes on both sides.
module add3_seq_ctrl #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SUM_W = WIDTH + 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SUM_W-1:0] sum,
  output logic             busy
);

  localparam int unsigned Levels = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StAdd1, StAdd2, StDone} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, c_q, c_d, s1_q, s1_d;
  logic               ci_q, ci_d, k1_q, k1_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic               out_valid_q, out_valid_d, busy_q, busy_d;

  // Shared adder operand selection
  logic [WIDTH-1:0]   add_x, add_y, add_s;
  logic               add_ci, add_co;

  always_comb begin
    add_x  = a_q;
    add_y  = b_q;
    add_ci = ci_q;
    if (state_q == StAdd2) begin
      add_x  = s1_q;
      add_y  = c_q;
      add_ci = 1'b0;
    end
  end

  // Kogge-Stone prefix network; the carry-in is folded in after the prefix tree.
  logic [WIDTH-1:0] gk [Levels+1];
  logic [WIDTH-1:0] pk [Levels+1];
  logic [WIDTH-1:0] carry;

  always_comb begin
    gk[0] = add_x & add_y;
    pk[0] = add_x ^ add_y;
    for (int l = 0; l < int'(Levels); l++) begin
      logic [WIDTH-1:0] low_mask;
      low_mask  = ~({WIDTH{1'b1}} << (1 << l));
      gk[l+1]   = gk[l] | (pk[l] & (gk[l] << (1 << l)));
      pk[l+1]   = pk[l] & ((pk[l] << (1 << l)) | low_mask);
    end
    carry  = {gk[Levels][WIDTH-2:0] | (pk[Levels][WIDTH-2:0] & {(WIDTH-1){add_ci}}), add_ci};
    add_s  = pk[0] ^ carry;
    add_co = gk[Levels][WIDTH-1] | (pk[Levels][WIDTH-1] & add_ci);
  end

  assign in_ready = ~rst & ((state_q == StIdle) | ((state_q == StDone) & out_ready));

  logic       accept;
  logic [1:0] khi;

  assign accept = in_valid & in_ready;
  assign khi    = {1'b0, k1_q} + {1'b0, add_co};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    ci_d    = ci_q;
    s1_d    = s1_q;
    k1_d    = k1_q;
    sum_d   = sum_q;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = StAdd1;
      end
      StAdd1: begin
        s1_d    = add_s;
        k1_d    = add_co;
        state_d = StAdd2;
      end
      StAdd2: begin
        sum_d   = SUM_W'({khi, add_s});
        state_d = StDone;
      end
      StDone: begin
        if (out_ready) state_d = accept ? StAdd1 : StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (accept) begin
      a_d  = a;
      b_d  = b;
      c_d  = c;
      ci_d = c_in;
    end
    out_valid_d = (state_d == StDone);
    busy_d      = (state_d == StAdd1) | (state_d == StAdd2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      ci_q        <= 1'b0;
      s1_q        <= '0;
      k1_q        <= 1'b0;
      sum_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      ci_q        <= ci_d;
      s1_q        <= s1_d;
      k1_q        <= k1_d;
      sum_q       <= sum_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign sum       = sum_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

endmodule
